// File: rtl/power_req_gen.sv
// Idle-driven power-down request generator: watches domain activity, requests sleep
// after a qualified idle run, enforces a minimum off time and sequences the wake-up.
module power_req_gen #(
  parameter int IDLE_CYCLES = 16,
  parameter int MIN_OFF     = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       activity,
  input  logic       sleep_en,
  input  logic       wake_req,
  input  logic       iso_en,
  input  logic       ret_en,
  output logic       p_flag,
  output logic [1:0] state,
  output logic       wake_pending,
  output logic [7:0] sleep_cnt
);

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    IDLE_WAIT = 2'd1,
    SLEEP     = 2'd2,
    WAKE      = 2'd3
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] HOLD_MIN  = 8'(MIN_OFF);

  state_t     cur_state;
  logic [7:0] idle_cnt;
  logic [7:0] hold_cnt;
  logic       idle_ok;

  assign idle_ok = sleep_en & ~activity;
  assign state   = cur_state;

  // NOTE: every register, outputs included, sits in the async reset branch and is
  // updated with <= only, so p_flag drops the instant RSTn falls and nothing races.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cur_state    <= ACTIVE;
      idle_cnt     <= 8'd0;
      hold_cnt     <= 8'd0;
      p_flag       <= 1'b0;
      wake_pending <= 1'b0;
      sleep_cnt    <= 8'd0;
    end else begin
      case (cur_state)
        ACTIVE: begin
          if (idle_ok) begin
            cur_state <= IDLE_WAIT;
            idle_cnt  <= 8'd1;
          end else begin
            idle_cnt  <= 8'd0;
          end
        end

        IDLE_WAIT: begin
          // Any activity, even on the final idle count, aborts the sleep attempt.
          if (!idle_ok) begin
            cur_state <= ACTIVE;
            idle_cnt  <= 8'd0;
          end else if (idle_cnt == IDLE_LAST) begin
            cur_state <= SLEEP;
            idle_cnt  <= 8'd0;
            hold_cnt  <= 8'd0;
            p_flag    <= 1'b1;
            if (sleep_cnt != 8'hFF) sleep_cnt <= sleep_cnt + 8'd1;
          end else begin
            idle_cnt  <= idle_cnt + 8'd1;
          end
        end

        SLEEP: begin
          if ((hold_cnt >= HOLD_MIN) && (wake_pending || wake_req)) begin
            cur_state    <= WAKE;
            p_flag       <= 1'b0;
            wake_pending <= 1'b0;
            hold_cnt     <= 8'd0;
          end else begin
            if (wake_req || !sleep_en) wake_pending <= 1'b1;
            // Saturate at the minimum so a long sleep cannot wrap the hold count.
            if (hold_cnt < HOLD_MIN) hold_cnt <= hold_cnt + 8'd1;
          end
        end

        WAKE: begin
          if (!iso_en && !ret_en) cur_state <= ACTIVE;
        end

        default: begin
          cur_state <= ACTIVE;
          idle_cnt  <= 8'd0;
          hold_cnt  <= 8'd0;
          p_flag    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_power_req_gen.sv
// Scoreboard bench for power_req_gen: stimulus pushes model predictions tagged with
// the clock edge they apply to; a negedge monitor pops and compares them.
module tb_power_req_gen;

  localparam int IDLE_CYCLES = 16;
  localparam int MIN_OFF     = 8;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       activity = 1'b0, sleep_en = 1'b0, wake_req = 1'b0;
  logic       iso_en = 1'b0, ret_en = 1'b0;
  logic       p_flag, wake_pending;
  logic [1:0] state;
  logic [7:0] sleep_cnt;

  power_req_gen #(.IDLE_CYCLES(IDLE_CYCLES), .MIN_OFF(MIN_OFF)) dut (
    .CLK(CLK), .RSTn(RSTn), .activity(activity), .sleep_en(sleep_en),
    .wake_req(wake_req), .iso_en(iso_en), .ret_en(ret_en), .p_flag(p_flag),
    .state(state), .wake_pending(wake_pending), .sleep_cnt(sleep_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       pf;
    logic       wp;
    logic [7:0] sc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: modes by name, idle run length, cycles spent asleep.
  int m_mode;   // 0 awake, 2 asleep, 3 waking; awake splits into 0/1 by idle run
  int m_run;
  int m_age;
  int m_cnt;
  bit m_pend;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.cyc < cyc) check("sb_stale", e.cyc, cyc);
      else begin
        check("state", int'(state), int'(e.st));
        check("p_flag", int'(p_flag), int'(e.pf));
        check("wake_pending", int'(wake_pending), int'(e.wp));
        check("sleep_cnt", int'(sleep_cnt), int'(e.sc));
      end
    end
  end

  function automatic logic [1:0] model_state();
    if (m_mode == 2) return 2'd2;
    if (m_mode == 3) return 2'd3;
    return (m_run == 0) ? 2'd0 : 2'd1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_age = 0; m_cnt = 0; m_pend = 0;
  endtask

  // Called at posedge+1; drives one cycle of inputs and predicts the post-edge outputs.
  task automatic step(input bit act, input bit sen, input bit wr, input bit iso, input bit ret);
    exp_t e;
    activity = act; sleep_en = sen; wake_req = wr; iso_en = iso; ret_en = ret;
    case (m_mode)
      0: begin
        m_run = (sen && !act) ? m_run + 1 : 0;
        if (m_run == IDLE_CYCLES) begin
          m_mode = 2; m_run = 0; m_age = 0;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      2: begin
        if (m_age >= MIN_OFF && (m_pend || wr)) begin
          m_mode = 3; m_pend = 0;
        end else begin
          if (wr || !sen) m_pend = 1;
          m_age++;
        end
      end
      default: if (!iso && !ret) begin m_mode = 0; m_run = 0; end
    endcase
    e.cyc = cyc + 1;
    e.st  = model_state();
    e.pf  = (m_mode == 2);
    e.wp  = m_pend;
    e.sc  = 8'(m_cnt);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge; leaves at posedge+1.
  task automatic do_reset();
    #2;
    RSTn = 1'b0;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_p_flag", int'(p_flag), 0);
    check("rst_wake_pending", int'(wake_pending), 0);
    check("rst_sleep_cnt", int'(sleep_cnt), 0);
    sb_q.delete();
    model_reset();
    activity = 1'b0; sleep_en = 1'b0; wake_req = 1'b0; iso_en = 1'b0; ret_en = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    int guard;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Straight idle run: p_flag must rise on edge IDLE_CYCLES.
    repeat (IDLE_CYCLES) step(0, 1, 0, 1, 1);
    // Wake pulse two cycles after entry, with iso/ret still held by the controller.
    step(0, 1, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    guard = 0;
    while (m_mode != 3 && guard < 40) begin step(1, 1, 0, 1, 1); guard++; end
    check("reach_wake", m_mode, 3);
    repeat (5) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);

    // Activity on the final idle count aborts the sleep.
    repeat (IDLE_CYCLES - 1) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (4) step(1, 1, 1, 0, 0);

    // Randomised traffic biased towards long idle runs.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 15) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    // Reset asserted while asleep must drop p_flag without a clock.
    guard = 0;
    while (m_mode != 2 && guard < 200) begin step(0, 1, 0, 1, 1); guard++; end
    check("reach_sleep", m_mode, 2);
    repeat (3) step(0, 1, 0, 1, 1);
    check("pre_rst_p_flag", int'(p_flag), 1);
    do_reset();

    // Repeated sleep/wake rounds until the entry counter saturates.
    guard = 0;
    while (m_cnt < 255 && guard < 20000) begin step(0, 1, 1, 0, 0); guard++; end
    check("saturate_model", m_cnt, 255);
    repeat (60) step(0, 1, 1, 0, 0);

    repeat (2) @(negedge CLK);
    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/power_req_gen.md
POWER_REQ_GEN -- requirements
Module: power_req_gen

Interface
REQ-001 The block SHALL have parameter IDLE_CYCLES, default 16, meaning consecutive idle cycles before a sleep request (legal 2..255).
REQ-002 The block SHALL have parameter MIN_OFF, default 8, meaning minimum cycles p_flag stays high once asserted (legal 1..255).
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port activity  input  1  domain busy indicator, high means not idle.
REQ-006 The block SHALL have port sleep_en  input  1  software permission to power down.
REQ-007 The block SHALL have port wake_req  input  1  external wake request, single-cycle pulse or level.
REQ-008 The block SHALL have port iso_en  input  1  isolation status returned by the downstream power controller.
REQ-009 The block SHALL have port ret_en  input  1  retention status returned by the downstream power controller.
REQ-010 The block SHALL have port p_flag  output  1  power-down request to the downstream power controller, high = power down.
REQ-011 The block SHALL have port state  output  2  current FSM state.
REQ-012 The block SHALL have port wake_pending  output  1  wake request latched but not yet served.
REQ-013 The block SHALL have port sleep_cnt  output  8  saturating count of sleep entries.

Function
REQ-014 The FSM SHALL have states ACTIVE=2'd0, IDLE_WAIT=2'd1, SLEEP=2'd2, WAKE=2'd3, all outputs registered.
REQ-015 In ACTIVE, when sleep_en=1 and activity=0, the next state SHALL be IDLE_WAIT with idle counter loaded to 1; otherwise the FSM stays in ACTIVE with the counter at 0.
REQ-016 In IDLE_WAIT, activity=1 or sleep_en=0 SHALL return the FSM to ACTIVE and clear the idle counter next cycle.
REQ-017 In IDLE_WAIT with activity=0 and sleep_en=1, the idle counter SHALL increment, and when it equals IDLE_CYCLES-1 the next state SHALL be SLEEP.
REQ-018 Activity=1 in the same cycle as the final idle count SHALL take priority: ACTIVE, no sleep.
REQ-019 p_flag SHALL be 1 exactly in SLEEP and rise on the same edge the FSM enters SLEEP, which is IDLE_CYCLES edges after the first idle cycle sampled in ACTIVE.
REQ-020 Entry to SLEEP SHALL increment sleep_cnt by 1, saturating at 8'hFF.
REQ-021 In SLEEP, a hold counter SHALL count from 0; the FSM SHALL NOT leave SLEEP before MIN_OFF cycles have elapsed.
REQ-022 In SLEEP, wake_req=1 or sleep_en=0 SHALL set wake_pending, and it stays set until the FSM enters WAKE.
REQ-023 In SLEEP, activity SHALL be ignored.
REQ-024 In SLEEP, once the hold count reaches MIN_OFF, wake_pending=1 or wake_req=1 SHALL move the FSM to WAKE and clear wake_pending on the same edge.
REQ-025 In WAKE, p_flag SHALL be 0, and the FSM SHALL return to ACTIVE on the first cycle with iso_en=0 and ret_en=0.
REQ-026 wake_req in ACTIVE, IDLE_WAIT or WAKE SHALL have no effect and SHALL NOT set wake_pending.
REQ-027 All counters SHALL be 8 bits; the idle counter and hold counter SHALL clear on every state exit.

Reset
REQ-028 RSTn=0 SHALL immediately, without a clock, force state=ACTIVE, p_flag=0, wake_pending=0, sleep_cnt=0, and both internal counters to 0.
REQ-029 A reset asserted mid-SLEEP SHALL drop p_flag asynchronously.
REQ-030 After RSTn rises, the first state transition SHALL occur no earlier than the next rising CLK edge.

Verification
REQ-031 Scenario: sleep_en=1, activity=0 from cycle 0, defaults -> p_flag rises at edge 16, state=2, sleep_cnt=1.
REQ-032 Scenario: idle run with activity=1 at idle count 15 -> state=0, p_flag never rises, sleep_cnt=0.
REQ-033 Scenario: wake_req pulse 2 cycles after SLEEP entry -> wake_pending=1, p_flag held until hold count reaches 8, then p_flag=0, state=3, wake_pending=0.
REQ-034 Scenario: in WAKE, hold iso_en=1 for 5 cycles then drive iso_en=0, ret_en=0 -> state stays 3, then becomes 0 the cycle after.
REQ-035 Scenario: RSTn=0 asynchronously mid-SLEEP -> p_flag=0 and state=0 before the next CLK edge, and sleep_cnt=0.
REQ-036 Scenario: 300 sleep/wake cycles -> sleep_cnt saturates at 8'hFF.
